// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: latches LedData once per frame,
// scans one digit per SCAN_DIV clocks, hex-encodes each nibble with optional leading-zero blanking.
module seg7_scan #(
    parameter int WIDTH    = 32,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] LedData,
    input  logic             blank_lz,
    output logic [7:0]       AN,
    output logic [6:0]       SEG
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic [2:0]       idx_r;
    logic [WIDTH-1:0] frame_r;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;

    logic             last_s;
    logic [3:0]       nib_s;
    logic [WIDTH-1:0] upper_s;
    logic             blank_s;
    logic [7:0]       an_next_s;
    logic [6:0]       seg_next_s;

    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Current-digit decode: nibble select, leading-zero test and next output values.
    always_comb begin
        last_s  = (div_cnt_r == DIV_LAST);
        nib_s   = frame_r[{idx_r, 2'b00} +: 4];
        // Digit idx is a leading zero when it and every digit to its left are zero.
        upper_s = frame_r >> {idx_r, 2'b00};
        blank_s = blank_lz & (idx_r != 3'd0) & (upper_s == {WIDTH{1'b0}});
        if (blank_s) begin
            an_next_s  = 8'hFF;
            seg_next_s = 7'h7F;
        end else begin
            an_next_s  = ~(8'h01 << idx_r);
            seg_next_s = enc(nib_s);
        end
    end

    // Dwell counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            idx_r     <= 3'd0;
        end else if (last_s) begin
            div_cnt_r <= {CNT_W{1'b0}};
            idx_r     <= idx_r + 3'd1;
        end else begin
            div_cnt_r <= div_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Frame latch, captured on the edge where the scan wraps from digit 7 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r <= {WIDTH{1'b0}};
        end else if (last_s && (idx_r == 3'd7)) begin
            frame_r <= LedData;
        end
    end

    // Registered pin drivers, one cycle behind idx/frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 8'hFF;
            seg_r <= 7'h7F;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign AN  = an_r;
    assign SEG = seg_r;

endmodule
